demux: RTL and testbench
========================

DEMUX -- requirements
Module: demux

Interface
REQ-001 Parameter WIDTH, default 1: bit width of the data input and of each data output.
REQ-002 Parameter IDLE_VAL, default 0 (WIDTH bits): value driven on non-selected outputs.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port d_in, input, WIDTH: data to route.
REQ-006 Port d_valid, input, 1: qualifies d_in/d_sel; when 0, no routing occurs that cycle.
REQ-007 Port d_sel, input, 2: selects destination output 0..3.
REQ-008 Ports d_out_0, d_out_1, d_out_2, d_out_3, output, WIDTH each: routed data.
REQ-009 Ports v_out_0 .. v_out_3, output, 1 each: per-output valid strobe.

Function
REQ-010 On a clock edge with d_valid=1, the output indexed by d_sel SHALL register d_in; latency is exactly 1 cycle.
REQ-011 In that same cycle, v_out_<d_sel> SHALL be 1 and all other v_out SHALL be 0 (one-hot).
REQ-012 On a clock edge with d_valid=0, all v_out SHALL be 0.
REQ-013 Non-selected d_out and all d_out in d_valid=0 cycles SHALL follow REQ-021/REQ-022.
REQ-014 All four d_sel codes are legal; no out-of-range condition exists.
REQ-015 Back-to-back valid cycles with changing d_sel SHALL route each beat independently, with no bubble.
REQ-016 Repeated selection of the same output SHALL update it every valid cycle.
REQ-017 Outputs SHALL be driven only from registers; there is no combinational path from input to output.

Reset
REQ-018 While rst=1 at a clock edge, all d_out SHALL become IDLE_VAL and all v_out SHALL become 0, regardless of d_valid.
REQ-019 Reset asserted mid-stream SHALL discard the beat presented in that cycle.
REQ-020 The first valid beat after rst falls SHALL appear at the outputs one cycle later.

Configuration
REQ-021 With macro DEMUX_HOLD_EN defined, non-selected outputs and all outputs during d_valid=0 cycles SHALL retain their previous registered value.
REQ-022 Without DEMUX_HOLD_EN, non-selected outputs and all outputs during d_valid=0 cycles SHALL be driven to IDLE_VAL on the next clock edge.
REQ-023 v_out behaviour SHALL be identical with and without DEMUX_HOLD_EN.

Structure
REQ-024 Package demux_pkg SHALL hold NUM_OUT=4, SEL_W=2, and an enumerated selection type (SEL_0..SEL_3).
REQ-025 One output-lane register SHALL be a sub-module named demux_lane, instantiated four times.
REQ-026 Each demux_lane SHALL have clk, rst, hit, d_in, d_out, and v_out ports.

Verification
REQ-027 Set WIDTH=1, rst=1 for 2 cycles, then rst=0, d_valid=1, d_in=1, d_sel=0,1,2,3 on consecutive cycles. Required outputs one cycle after each: d_out=1000, 0100, 0010, 0001 (out_0..out_3) in the non-hold build, and v_out one-hot matching.
REQ-028 Hold build, same stimulus as REQ-027. Required: after the fourth beat, all d_out=1 and v_out=0001.
REQ-029 Drive d_valid=0 with d_sel=2 and d_in=1. Required: all v_out=0; in the non-hold build all d_out=IDLE_VAL.
REQ-030 Set WIDTH=8, d_in=8'hA5, d_sel=3, then d_in=8'h3C, d_sel=3. Required: d_out_3 shows A5 then 3C on consecutive cycles, and v_out_3 stays high.
REQ-031 Assert rst in a cycle with d_valid=1, d_sel=1, d_in=1. Required: next cycle d_out_1=IDLE_VAL and v_out_1=0.
REQ-032 Sweep all d_sel values randomly for 1000 cycles and compare against a reference model. Required: zero mismatches, and at most one v_out is high in every cycle.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants, selection type and select decoder for the 1-to-4 demux.
package demux_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [SEL_W-1:0] {
    SEL_0 = 2'd0,
    SEL_1 = 2'd1,
    SEL_2 = 2'd2,
    SEL_3 = 2'd3
  } sel_e;

  // One-hot lane strobe; all zero when the beat is not valid.
  function automatic logic [NUM_OUT-1:0] sel_onehot(input logic valid, input sel_e sel);
    logic [NUM_OUT-1:0] w_onehot;
    w_onehot = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      w_onehot[i] = valid && (int'(sel) == i);
    end
    return w_onehot;
  endfunction

endpackage

// File: rtl/demux_lane.sv
// One registered output lane of the demux.
// DEMUX_HOLD_EN: unselected lanes keep their value instead of returning to IDLE_VAL.
module demux_lane
  import demux_pkg::*;
#(
  parameter int               WIDTH    = 1,
  parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             v_out
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [WIDTH-1:0] w_data_nxt;

  always_comb begin
    w_data_nxt = IDLE_VAL;
    if (hit) begin
      w_data_nxt = d_in;
    end else begin
`ifdef DEMUX_HOLD_EN
      w_data_nxt = r_data;
`else
      w_data_nxt = IDLE_VAL;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= IDLE_VAL;
      r_valid <= 1'b0;
    end else begin
      r_data  <= w_data_nxt;
      r_valid <= hit;
    end
  end

  assign d_out = r_data;
  assign v_out = r_valid;

endmodule

// File: rtl/demux.sv
// 1-to-4 registered demultiplexer with per-output valid strobes.
// DEMUX_HOLD_EN (see demux_lane) selects hold vs. idle behaviour of unselected outputs.
module demux
  import demux_pkg::*;
#(
  parameter int               WIDTH    = 1,
  parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_valid,
  input  logic [1:0]       d_sel,
  output logic [WIDTH-1:0] d_out_0,
  output logic [WIDTH-1:0] d_out_1,
  output logic [WIDTH-1:0] d_out_2,
  output logic [WIDTH-1:0] d_out_3,
  output logic             v_out_0,
  output logic             v_out_1,
  output logic             v_out_2,
  output logic             v_out_3
);

  sel_e               w_sel;
  logic [NUM_OUT-1:0] w_hit;
  logic [WIDTH-1:0]   w_d_out [NUM_OUT];
  logic [NUM_OUT-1:0] w_v_out;

  assign w_sel = sel_e'(d_sel);
  assign w_hit = sel_onehot(d_valid, w_sel);

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_lane
    demux_lane #(
      .WIDTH    (WIDTH),
      .IDLE_VAL (IDLE_VAL)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .hit   (w_hit[g]),
      .d_in  (d_in),
      .d_out (w_d_out[g]),
      .v_out (w_v_out[g])
    );
  end

  assign d_out_0 = w_d_out[0];
  assign d_out_1 = w_d_out[1];
  assign d_out_2 = w_d_out[2];
  assign d_out_3 = w_d_out[3];
  assign v_out_0 = w_v_out[0];
  assign v_out_1 = w_v_out[1];
  assign v_out_2 = w_v_out[2];
  assign v_out_3 = w_v_out[3];

endmodule

// File: tb/tb_demux.sv
// Self-checking bench: an 8-bit and a 1-bit demux share one stimulus stream and
// are checked every cycle against a per-output model plus literal expectations.
module tb_demux;

  localparam logic [7:0] IDLE8 = 8'h5A;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_valid;
  logic [1:0] d_sel;
  logic [7:0] d_in;

  logic [7:0] a0, a1, a2, a3;
  logic       av0, av1, av2, av3;
  logic       b0, b1, b2, b3;
  logic       bv0, bv1, bv2, bv3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux #(.WIDTH(8), .IDLE_VAL(IDLE8)) u_w8 (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .d_sel(d_sel),
    .d_out_0(a0), .d_out_1(a1), .d_out_2(a2), .d_out_3(a3),
    .v_out_0(av0), .v_out_1(av1), .v_out_2(av2), .v_out_3(av3)
  );

  demux u_w1 (
    .clk(clk), .rst(rst), .d_in(d_in[0]), .d_valid(d_valid), .d_sel(d_sel),
    .d_out_0(b0), .d_out_1(b1), .d_out_2(b2), .d_out_3(b3),
    .v_out_0(bv0), .v_out_1(bv1), .v_out_2(bv2), .v_out_3(bv3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each output independently follows the routing rules.
  logic [7:0] m8 [4];
  logic       m1 [4];
  logic [3:0] mv;
  bit         model_ok = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      mv[k] = !rst && d_valid && (int'(d_sel) == k);
      if (rst) begin
        m8[k] = IDLE8;
        m1[k] = 1'b0;
      end else if (mv[k]) begin
        m8[k] = d_in;
        m1[k] = d_in[0];
      end else begin
`ifndef DEMUX_HOLD_EN
        m8[k] = IDLE8;
        m1[k] = 1'b0;
`endif
      end
    end
    if (rst) model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("w8_dout", {a0, a1, a2, a3}, {m8[0], m8[1], m8[2], m8[3]});
      check("w8_vout", {28'd0, av0, av1, av2, av3}, {28'd0, mv[0], mv[1], mv[2], mv[3]});
      check("w1_dout", {28'd0, b0, b1, b2, b3}, {28'd0, m1[0], m1[1], m1[2], m1[3]});
      check("w1_vout", {28'd0, bv0, bv1, bv2, bv3}, {28'd0, mv[0], mv[1], mv[2], mv[3]});
      check("onehot", {31'd0, $countones({av0, av1, av2, av3}) <= 1}, 32'd1);
    end
  end

  task automatic drive(input logic r, input logic v, input logic [1:0] s, input logic [7:0] din);
    rst     = r;
    d_valid = v;
    d_sel   = s;
    d_in    = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; d_valid = 1'b0; d_sel = 2'd0; d_in = 8'd0;
    drive(1'b1, 1'b0, 2'd0, 8'h00);
    drive(1'b1, 1'b1, 2'd2, 8'hFF);
    check("rst_w8_dout", {a0, a1, a2, a3}, {IDLE8, IDLE8, IDLE8, IDLE8});
    check("rst_w1_dout", {28'd0, b0, b1, b2, b3}, 32'h0);
    check("rst_vout", {28'd0, av0, av1, av2, av3}, 32'h0);

    // Walk a single 1 across the four outputs.
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, 1'b1, s[1:0], 8'h01);
`ifdef DEMUX_HOLD_EN
      check("walk_w1_dout", {28'd0, b0, b1, b2, b3}, 32'hF0 >> (s + 1) & 32'hF);
`else
      check("walk_w1_dout", {28'd0, b0, b1, b2, b3}, 32'h8 >> s);
`endif
      check("walk_vout", {28'd0, bv0, bv1, bv2, bv3}, 32'h8 >> s);
    end

    // Invalid beat must not route.
    drive(1'b0, 1'b0, 2'd2, 8'h01);
    check("inv_vout", {28'd0, av0, av1, av2, av3}, 32'h0);
`ifdef DEMUX_HOLD_EN
    check("inv_w1_dout", {28'd0, b0, b1, b2, b3}, 32'hF);
`else
    check("inv_w1_dout", {28'd0, b0, b1, b2, b3}, 32'h0);
    check("inv_w8_dout", {a0, a1, a2, a3}, {IDLE8, IDLE8, IDLE8, IDLE8});
`endif

    // Same output twice in a row.
    drive(1'b0, 1'b1, 2'd3, 8'hA5);
    check("rep_a5", {24'd0, a3}, 32'hA5);
    check("rep_v1", {31'd0, av3}, 32'd1);
    drive(1'b0, 1'b1, 2'd3, 8'h3C);
    check("rep_3c", {24'd0, a3}, 32'h3C);
    check("rep_v2", {31'd0, av3}, 32'd1);

    // Reset discards the beat presented alongside it.
    drive(1'b1, 1'b1, 2'd1, 8'h01);
    check("rstmid_d1", {24'd0, a1}, {24'd0, IDLE8});
    check("rstmid_w1", {31'd0, b1}, 32'd0);
    check("rstmid_v1", {31'd0, av1}, 32'd0);
    drive(1'b0, 1'b1, 2'd2, 8'h77);
    check("post_rst_d2", {24'd0, a2}, 32'h77);
    check("post_rst_v", {28'd0, av0, av1, av2, av3}, 32'h2);

    for (int i = 0; i < 1000; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 8'($urandom));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
